// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PKG_ADDR_W  = 64;
  localparam int unsigned PKG_INSTR_W = 32;

  // Legacy state encodings, kept so existing waveforms/decoders still match.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef enum logic [0:0] {
    RUN  = ST_RUN,
    HALT = ST_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [PKG_INSTR_W-1:0] instr;
    logic [PKG_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {instr, pc} entries with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop & valid;
  assign valid  = (count != '0);
  assign head   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything, even a same-edge pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: drives the ROM address, buffers words with their PC, handles redirects and faults.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fault
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  fetch_state_t      state;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              space;
  logic              push;
  logic              pc_bad;
  logic              target_bad;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // Misaligned, or the last byte of the word lies beyond the ROM.
  function automatic logic bad_addr(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) ||
           ((a + ADDR_W'(INSTR_BYTES - 1)) >= ADDR_W'(MEM_SIZE));
  endfunction

  assign pc_bad     = bad_addr(fetch_pc);
  assign target_bad = bad_addr(redirect_target);
  assign pop        = out_valid & out_ready;
  assign space      = (count < CNT_W'(DEPTH)) | pop;
  assign push       = (state == RUN) & ~redirect_valid & ~pc_bad & space;
  assign push_entry = '{instr: imem_instruction, pc: fetch_pc};

  assign imem_address    = fetch_pc;
  assign out_instruction = head.instr;
  assign out_pc          = head.pc;

  // PC, run/halt state and sticky fault; redirect overrides both push and fault check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= ADDR_W'(RESET_PC);
      state    <= RUN;
      fault    <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      state    <= target_bad ? HALT : RUN;
      fault    <= target_bad;
    end else if (state == RUN) begin
      if (pc_bad) begin
        state <= HALT;
        fault <= 1'b1;
      end else if (space) begin
        fetch_pc <= fetch_pc + ADDR_W'(INSTR_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .valid      (out_valid),
    .count      (count)
  );

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Requester side of the combinational instruction ROM interface. It owns the fetch PC, drives the 64-bit byte address to the ROM, and captures the returned 32-bit word. Each word is buffered with its PC in a small FIFO and handed to decode over a valid/ready handshake. It also handles branch redirects, flushing and out-of-range fetch faults.

Parameters:
ADDR_W, 64, width of PC and ROM address
INSTR_W, 32, instruction width
MEM_SIZE, 1024, ROM size in bytes; power of two, greater than 4
RESET_PC, 0, PC loaded on reset; word-aligned
DEPTH, 2, fetch FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
imem_address  out  ADDR_W  byte address to ROM; always equals fetch_pc
imem_instruction  in  INSTR_W  combinational ROM data for imem_address
redirect_valid  in  1  single-cycle branch/jump redirect request
redirect_target  in  ADDR_W  new fetch PC
out_valid  out  1  FIFO head is valid
out_ready  in  1  decode accepts head this cycle
out_instruction  out  INSTR_W  head instruction
out_pc  out  ADDR_W  head PC
fault  out  1  sticky fetch fault (misaligned or out of bounds)

Behaviour:
- Clock and reset: one clock domain (clk). reset_n is asynchronous and active-low.
- Reset values: fetch_pc = RESET_PC; FIFO empty (count = 0, pointers = 0); state = RUN; fault = 0; out_valid = 0.
- Outputs: out_instruction and out_pc are driven from the FIFO head. Their value is don't-care when out_valid = 0.
- Signals used below:
  - pop = out_valid & out_ready
  - space = (count < DEPTH) | pop
  - bad(a) = (a[1:0] != 0) | (a + 3 >= MEM_SIZE)
- States: RUN and HALT.
- RUN, no redirect, bad(fetch_pc) = 0, space = 1:
  - push {imem_instruction, fetch_pc};
  - fetch_pc += 4.
- RUN, space = 0: hold fetch_pc; no push.
- RUN, bad(fetch_pc) = 1:
  - no push;
  - go to HALT and set fault = 1;
  - entries already in the FIFO still drain normally.
- HALT: no pushes; fetch_pc holds its value.
- Redirect (any state) has priority over push and over the fault check:
  - FIFO flushed (count = 0) at that edge, including any simultaneous pop;
  - fetch_pc <= redirect_target.
- Redirect target checks:
  - bad(redirect_target) = 1: state = HALT, fault = 1.
  - otherwise: state = RUN, fault cleared.
  - This is the only way to leave HALT.
- Latency:
  - a word is pushed at the edge where its PC is presented;
  - out_valid rises the cycle after, so fetch-to-decode latency is 1 cycle;
  - after reset release, mem[RESET_PC/4] appears at the head after the first rising edge.
- Throughput: with out_ready held at 1, one instruction per cycle. Consecutive out_pc values differ by exactly 4.
- Backpressure:
  - when count = DEPTH and out_ready = 0, nothing is pushed and fetch_pc holds;
  - no entry is ever lost or duplicated.
- Simultaneous pop and push when full: allowed. count is unchanged and both pointers advance.
- Pointer wrap-around: pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.
- fetch_pc arithmetic: modulo 2^ADDR_W. The bounds check catches overflow before wrap can matter.
- Reset asserted mid-stream: all state returns to its reset value immediately, with no clock edge needed.

Decomposition:
- Shared package fetch_pkg holds:
  - typedef fetch_state_t {RUN, HALT};
  - typedef fetch_entry_t struct {instr, pc};
  - constant INSTR_BYTES = 4.
- One natural sub-module, fetch_fifo: a DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, and asynchronous active-low reset.
- The top level holds the PC register, the state machine and the bounds check.

Test Plan:
- Reset then run: after reset, out_ready = 1, ROM words 0..7 distinct. Required: out_pc = 0, 4, 8 … 28 on consecutive cycles, each with the matching word; fault = 0.
- Backpressure: out_ready = 0 for 5 cycles. Required: count saturates at 2 and fetch_pc holds at 8. After out_ready = 1, out_pc continues 0, 4, 8, 12 with no gaps or repeats.
- Redirect with full FIFO and simultaneous pop: redirect_target = 0x40. Required: flushed entry is not delivered; next out_pc = 0x40 one cycle later, then 0x44.
- End of memory: redirect to 0x3F8. Required: entries 0x3F8 and 0x3FC are delivered; fetch at 0x400 sets fault = 1 and enters HALT; no further out_valid; fault holds until the next redirect.
- Misaligned redirect: redirect_target = 0x42. Required: fault = 1, HALT, FIFO empty. A following redirect to 0x10 clears fault and out_pc = 0x10 next cycle.
- Asynchronous reset mid-stream: drop reset_n between clock edges. Required: out_valid = 0, fault = 0 and imem_address = RESET_PC immediately, with no clock edge.
